core_trace_buf: RTL

Parametrised retirement trace buffer for the pipelined RV32 core. It captures one record per retired instruction (pc, ir, rd, write data) from the write-back stage into a circular buffer. A PC-match or forced trigger freezes capture a programmable number of retirements later. Once frozen, the buffer is read out and a halt request is raised, giving the bench and on-chip debug a synthesizable view of the instruction stream.

---
 rtl/core_trace_buf.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/core_trace_buf.sv
// core_trace_buf
//   Retirement trace buffer. Captures one record (pc, ir, rd, data) per
//   retired instruction into a circular buffer. A PC-match or forced trigger
//   freezes capture POST retirements later; the frozen buffer is then
//   readable and halt_req is raised.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   wb_valid/pc/ir/rd/data     write-back retirement record
//   arm                        start a new capture (pulse)
//   trig_en, trig_pc           PC-match trigger enable and address
//   force_trig                 immediate trigger (pulse)
//   rd_addr                    logical read index, 0 = oldest entry
//   rd_pc/ir/rd/data           registered read data (0 when rd_addr >= count)
//   state                      0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   count                      valid entries, saturating at DEPTH
//   trig_idx                   logical index of the trigger entry (valid in DONE)
//   halt_req                   high in DONE
module core_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int POST  = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [31:0]     wb_ir,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            arm,
  input  logic            trig_en,
  input  logic [XLEN-1:0] trig_pc,
  input  logic            force_trig,
  input  logic [AW-1:0]   rd_addr,
  output logic [XLEN-1:0] rd_pc,
  output logic [31:0]     rd_ir,
  output logic [4:0]      rd_rd,
  output logic [XLEN-1:0] rd_data,
  output logic [1:0]      state,
  output logic [AW:0]     count,
  output logic [AW:0]     trig_idx,
  output logic            halt_req
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ir;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } rec_t;

  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] POST_C  = (AW+1)'(POST);
  // A forced trigger with no retirement has no trigger entry of its own, so
  // one extra retirement is captured to keep POST entries after the slot.
  localparam logic [AW:0] POST_P1 = (AW+1)'(POST + 1);

  // Storage is not reset; validity is tracked by count_q.
  rec_t mem [DEPTH];

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [AW:0]     post_left_q, post_left_d;
  logic [AW-1:0]   trig_phys_q, trig_phys_d;
  logic            halt_q, halt_d;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d;
  logic [31:0]     rd_ir_q, rd_ir_d;
  logic [4:0]      rd_rd_q, rd_rd_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic            we;
  logic            trig_hit;
  logic [AW-1:0]   oldest;
  logic [AW-1:0]   phys;
  logic            in_range;
  rec_t            wr_rec;
  rec_t            rd_rec;

  assign trig_hit = (trig_en & wb_valid & (wb_pc == trig_pc)) | force_trig;

  // Once full, the slot about to be overwritten holds the oldest record.
  assign oldest   = (count_q == FULL) ? wr_ptr_q : '0;
  assign phys     = oldest + rd_addr;
  assign in_range = ({1'b0, rd_addr} < count_q);

  assign wr_rec = '{pc: wb_pc, ir: wb_ir, rd: wb_rd, data: wb_data};
  assign rd_rec = mem[phys];

  // Capture / trigger control.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    post_left_d = post_left_q;
    trig_phys_d = trig_phys_q;
    we          = 1'b0;

    unique case (state_q)
      S_IDLE: ;
      S_ARMED: begin
        if (wb_valid) begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = (count_q == FULL) ? count_q : count_q + (AW+1)'(1);
        end
        if (trig_hit) begin
          trig_phys_d = wr_ptr_q;
          if (POST == 0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_POST;
            post_left_d = wb_valid ? POST_C : POST_P1;
          end
        end
      end
      S_POST: begin
        if (wb_valid) begin
          we          = 1'b1;
          wr_ptr_d    = wr_ptr_q + AW'(1);
          count_d     = (count_q == FULL) ? count_q : count_q + (AW+1)'(1);
          post_left_d = post_left_q - (AW+1)'(1);
          if (post_left_q == (AW+1)'(1)) state_d = S_DONE;
        end
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    // A restart outranks anything else happening this cycle, including the
    // write of a coincident retirement.
    if (arm) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      count_d     = '0;
      post_left_d = '0;
      trig_phys_d = '0;
      we          = 1'b0;
    end
  end

  assign halt_d = (state_d == S_DONE);

  // Readout: out-of-range reads return zeros.
  always_comb begin
    rd_pc_d   = '0;
    rd_ir_d   = '0;
    rd_rd_d   = '0;
    rd_data_d = '0;
    if (in_range) begin
      rd_pc_d   = rd_rec.pc;
      rd_ir_d   = rd_rec.ir;
      rd_rd_d   = rd_rec.rd;
      rd_data_d = rd_rec.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      post_left_q <= '0;
      trig_phys_q <= '0;
      halt_q      <= 1'b0;
      rd_pc_q     <= '0;
      rd_ir_q     <= '0;
      rd_rd_q     <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      post_left_q <= post_left_d;
      trig_phys_q <= trig_phys_d;
      halt_q      <= halt_d;
      rd_pc_q     <= rd_pc_d;
      rd_ir_q     <= rd_ir_d;
      rd_rd_q     <= rd_rd_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Reset is folded into the write enable so an aborted cycle writes nothing.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_ptr_q] <= wr_rec;
  end

  assign state    = state_q;
  assign count    = count_q;
  assign trig_idx = {1'b0, trig_phys_q - oldest};
  assign halt_req = halt_q;
  assign rd_pc    = rd_pc_q;
  assign rd_ir    = rd_ir_q;
  assign rd_rd    = rd_rd_q;
  assign rd_data  = rd_data_q;

endmodule
